// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetcher
// Presents fetched instructions with their PC; freezes on the all-zero HALT word.
module instr_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             instr_valid,
  output logic [INS_W-1:0] instr,
  output logic [PC_W-1:0]  instr_pc,
  output logic [PC_W-1:0]  pc_plus4,
  output logic             halted
);

  typedef enum logic [2:0] {START, FETCH, WAIT, ISSUE, HALTED} state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             drop_q, drop_d;
  logic             req_q, req_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic             ivalid_q, ivalid_d;
  logic [INS_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]  ipc_q, ipc_d;
  logic [PC_W-1:0]  pcp4_q, pcp4_d;
  logic             halted_q, halted_d;
  logic [PC_W-1:0]  target;

  assign target = {redirect_pc[PC_W-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    ivalid_d = ivalid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    pcp4_d   = pcp4_q;
    halted_d = halted_q;

    case (state_q)
      START: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = target;
      end
      FETCH: begin
        state_d = WAIT;
        // The request is already on the bus; its response must be thrown away.
        if (redirect_valid) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (redirect_valid || drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
            if (redirect_valid) pc_d = target;
          end else if (imem_rdata == '0) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            instr_d  = imem_rdata;
            ipc_d    = pc_q;
            pcp4_d   = pc_q + PC_STEP;
            ivalid_d = 1'b1;
            state_d  = ISSUE;
          end
        end else if (redirect_valid) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      ISSUE: begin
        if (redirect_valid) begin
          pc_d     = target;
          ivalid_d = 1'b0;
          state_d  = FETCH;
        end else if (!stall) begin
          pc_d     = pc_q + PC_STEP;
          ivalid_d = 1'b0;
          state_d  = FETCH;
        end
      end
      default: ;
    endcase

    // Outputs are registered, so the strobe is raised as FETCH is entered.
    if (state_d == FETCH) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= START;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      ivalid_q <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      pcp4_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      ivalid_q <= ivalid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      pcp4_q   <= pcp4_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = ivalid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc_plus4    = pcp4_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit with a transaction-level model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_valid, stall, redirect_valid, instr_valid, halted;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, pc_plus4;

  logic        req8, v8, r8v, iv8, h8;
  logic [7:0]  addr8, r8pc, ip8, pp8;
  logic [31:0] d8, i8;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_fetch_unit #(.PC_W(32), .INS_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_plus4(pc_plus4), .halted(halted));

  instr_fetch_unit #(.PC_W(8), .INS_W(32), .RESET_PC(8'h0)) dut8 (
    .clk(clk), .rst_n(rst_n), .imem_req(req8), .imem_addr(addr8),
    .imem_valid(v8), .imem_rdata(d8), .stall(1'b0),
    .redirect_valid(r8v), .redirect_pc(r8pc),
    .instr_valid(iv8), .instr(i8), .instr_pc(ip8),
    .pc_plus4(pp8), .halted(h8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Instruction memory contents: program words at 0/4/8, a nonzero hash elsewhere.
  logic [31:0] halt_addr = 32'h1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'h0;
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h002081B3;
      default: return ((a * 32'h9E3779B1) ^ 32'h00000013) | 32'h1;
    endcase
  endfunction

  // Memory: captures each request, answers after a latency of lat (or random) cycles.
  bit          rnd = 1'b0;
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  // Model state: next PC to fetch/present, and what must be visible.
  logic [31:0] exp_pc;
  bit          exp_iv, exp_halt, outst, stale;
  int          consumed = 0;

  always @(posedge clk) begin
    bit iv0;
    if (!rst_n) begin
      exp_pc = 32'h0; exp_iv = 0; exp_halt = 0; outst = 0; stale = 0;
    end else if (!exp_halt) begin
      iv0 = exp_iv;
      if (imem_valid && outst) begin
        outst = 0;
        if (stale || redirect_valid) stale = 0;
        else if (imem_rdata == 32'h0) exp_halt = 1;
        else exp_iv = 1;
      end
      if (imem_req) outst = 1;
      if (!exp_halt) begin
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'h3;
          if (outst) stale = 1;
          exp_iv = 0;
        end else if (iv0 && !stall) begin
          exp_pc = exp_pc + 32'h4;
          exp_iv = 0;
          consumed++;
        end
      end
    end
    if (rst_n && imem_req) begin
      pend  = 1;
      paddr = imem_addr;
      cnt   = rnd ? int'($urandom_range(1, 4)) : lat;
    end
  end

  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (!rst_n) pend = 0;
    else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(paddr);
        pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
      chk("halted", {31'b0, halted}, {31'b0, exp_halt});
      if (exp_iv) begin
        chk("instr_pc", instr_pc, exp_pc);
        chk("pc_plus4", pc_plus4, exp_pc + 32'h4);
        chk("instr", instr, mem_word(exp_pc));
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_pc);
        chk("imem_req_legal", {31'b0, outst | exp_iv | exp_halt}, 32'h0);
      end
    end
  end

  // Narrow-PC instance: one-cycle responder and wrap check.
  bit p8 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin v8 = 0; p8 = 0; end
    else begin v8 = p8; p8 = req8; end
    d8 = 32'h00000013;
  end

  initial begin
    int n;
    r8v = 0; r8pc = 8'h0;
    @(posedge rst_n);
    r8v = 1; r8pc = 8'hFC;
    @(negedge clk);
    r8v = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!iv8 && n < 50);
    chk("pw8_issue", {31'b0, iv8}, 32'h1);
    chk("pw8_instr_pc", {24'b0, ip8}, 32'hFC);
    chk("pw8_pc_plus4", {24'b0, pp8}, 32'h00);
    chk("pw8_instr", i8, 32'h00000013);
    n = 0;
    do begin @(negedge clk); n++; end while (!req8 && n < 50);
    chk("pw8_req", {31'b0, req8}, 32'h1);
    chk("pw8_wrap_addr", {24'b0, addr8}, 32'h00);
  end

  task automatic wait_iv(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!instr_valid && n < 100);
    chk(nm, {31'b0, instr_valid}, 32'h1);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!imem_req && n < 100);
    chk(nm, {31'b0, imem_req}, 32'h1);
  endtask

  initial begin
    int t1, n;
    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_valid = 0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_iv", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pcp4", pc_plus4, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    rst_n = 1;

    wait_req("first_req");
    chk("first_addr", imem_addr, 32'h0);
    wait_iv("issue0");
    chk("issue0_instr", instr, 32'h00500093);
    chk("issue0_pc", instr_pc, 32'h0);
    chk("issue0_pcp4", pc_plus4, 32'h4);
    t1 = cyc;
    wait_iv("issue1");
    chk("issue1_instr", instr, 32'h00100113);
    chk("issue1_pc", instr_pc, 32'h4);
    chk("issue1_pcp4", pc_plus4, 32'h8);
    chk("issue_gap", cyc - t1, 32'd3);

    wait_iv("issue2");
    chk("issue2_pc", instr_pc, 32'h8);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_iv", {31'b0, instr_valid}, 32'h1);
      chk("stall_instr", instr, 32'h002081B3);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_noreq", {31'b0, imem_req}, 32'h0);
    end
    stall = 0;
    wait_req("req_after_stall");
    chk("addr_after_stall", imem_addr, 32'hC);

    wait_iv("issue3");
    wait_iv("issue4");
    chk("issue4_pc", instr_pc, 32'h10);
    redirect_valid = 1; redirect_pc = 32'h43; lat = 5;
    @(negedge clk);
    redirect_valid = 0;
    chk("redir_iv_drop", {31'b0, instr_valid}, 32'h0);
    chk("redir_req", {31'b0, imem_req}, 32'h1);
    chk("redir_addr", imem_addr, 32'h40);
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 0;
    wait_req("req_after_wait_redir");
    chk("addr_after_wait_redir", imem_addr, 32'h80);
    lat = 1;
    wait_iv("issue_80");
    chk("issue_80_pc", instr_pc, 32'h80);

    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = (($urandom % 3) == 0) ? (32'hFFFFFFFC | ($urandom % 4)) : $urandom;
    end
    chk("random_progress", {31'b0, consumed > 200}, 32'h1);

    rnd = 0; stall = 0;
    redirect_valid = 1; redirect_pc = 32'h0C;
    @(negedge clk);
    redirect_valid = 0;
    halt_addr = 32'h14;
    n = 0;
    do begin @(negedge clk); n++; end while (!halted && n < 100);
    chk("halt_seen", {31'b0, halted}, 32'h1);
    redirect_valid = 1; redirect_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_noreq", {31'b0, imem_req}, 32'h0);
      chk("halt_noiv", {31'b0, instr_valid}, 32'h0);
      chk("halt_hold", {31'b0, halted}, 32'h1);
    end
    redirect_valid = 0;
    rst_n = 0;
    @(negedge clk);
    chk("halt_rst_clear", {31'b0, halted}, 32'h0);
    rst_n = 1;
    halt_addr = 32'h1;
    wait_req("restart_req");
    chk("restart_addr", imem_addr, 32'h0);
    wait_iv("restart_issue");
    chk("restart_instr", instr, 32'h00500093);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
